// File: rtl/snake_pkg.sv
// Shared types and default geometry for the snake movement controller.
package snake_pkg;

   localparam int DEF_GRID_W   = 32;
   localparam int DEF_GRID_H   = 24;
   localparam int DEF_MAX_LEN  = 64;
   localparam int DEF_INIT_LEN = 3;
   localparam int CW           = 5;

   typedef enum logic [1:0] {
      RIGHT = 2'd0,
      LEFT  = 2'd1,
      UP    = 2'd2,
      DOWN  = 2'd3
   } dir_t;

   typedef enum logic [2:0] {
      IDLE,
      MOVE,
      SCAN,
      COMMIT,
      GAME_OVER
   } state_t;

   // Opposite directions differ only in bit 0 of the encoding.
   function automatic logic is_reverse(input dir_t a, input dir_t b);
      logic [1:0] d;
      d = a ^ b;
      return d == 2'b01;
   endfunction

endpackage

// File: rtl/snake_dir_reg.sv
// Key decode and reversal filter; holds the pending and the committed direction.
module snake_dir_reg
   import snake_pkg::*;
(
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic [3:0] key_dir,
   input  logic       load,
   input  logic       reinit,
   output dir_t       next_dir
);

   dir_t dir;
   dir_t key_d;
   dir_t ref_dir;
   logic key_ok;

   always_comb begin
      key_d  = RIGHT;
      key_ok = 1'b1;
      case (key_dir)
         4'b1000: key_d = UP;
         4'b0100: key_d = DOWN;
         4'b0010: key_d = LEFT;
         4'b0001: key_d = RIGHT;
         default: key_ok = 1'b0;
      endcase
   end

   // Filter against the direction that will be in force after this edge.
   assign ref_dir = load ? next_dir : dir;

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dir      <= RIGHT;
         next_dir <= RIGHT;
      end else if (reinit) begin
         dir      <= RIGHT;
         next_dir <= RIGHT;
      end else begin
         if (key_ok && !is_reverse(key_d, ref_dir)) next_dir <= key_d;
         if (load) dir <= next_dir;
      end
   end

endmodule

// File: rtl/snake_move_ctrl.sv
// Advances the snake one cell per step_tick, detects wall/self hits, serves the body to the renderer.
// Build option: define WRAP_WALLS_EN to wrap the head across grid edges instead of ending the game.
module snake_move_ctrl
   import snake_pkg::*;
#(
   parameter int GRID_W   = DEF_GRID_W,
   parameter int GRID_H   = DEF_GRID_H,
   parameter int MAX_LEN  = DEF_MAX_LEN,
   parameter int INIT_LEN = DEF_INIT_LEN,
   localparam int IW      = $clog2(MAX_LEN),
   localparam int LW      = IW + 1
)(
   input  logic          vga_clk,
   input  logic          sys_rst_n,
   input  logic          step_tick,
   input  logic [3:0]    key_dir,
   input  logic          grow,
   input  logic          restart,
   input  logic [IW-1:0] seg_idx,
   output logic [CW-1:0] seg_x,
   output logic [CW-1:0] seg_y,
   output logic          seg_vld,
   output logic [CW-1:0] head_x,
   output logic [CW-1:0] head_y,
   output logic [LW-1:0] snake_len,
   output logic          move_done,
   output logic          game_over
);

`ifdef WRAP_WALLS_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam logic [LW-1:0] LEN_INIT = LW'(INIT_LEN);
   localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

   state_t                     state;
   dir_t                       move_dir;
   logic [MAX_LEN-1:0][CW-1:0] bx, by;
   logic [CW-1:0]              nh_x, nh_y, nx, ny;
   logic [IW-1:0]              k, k_last;
   logic [LW-1:0]              len;
   logic                       grow_pend, edge_hit, wall, hit, reinit;

   function automatic logic [CW-1:0] init_x(input int i);
      return (i < INIT_LEN) ? CW'(GRID_W / 2 - i) : '0;
   endfunction

   function automatic logic [CW-1:0] init_y(input int i);
      return (i < INIT_LEN) ? CW'(GRID_H / 2) : '0;
   endfunction

   assign reinit = (state == GAME_OVER) && restart;

   snake_dir_reg u_dir (
      .vga_clk   (vga_clk),
      .sys_rst_n (sys_rst_n),
      .key_dir   (key_dir),
      .load      (state == MOVE),
      .reinit    (reinit),
      .next_dir  (move_dir)
   );

   always_comb begin
      nx       = bx[0];
      ny       = by[0];
      edge_hit = 1'b0;
      case (move_dir)
         RIGHT: if (bx[0] == CW'(GRID_W - 1)) begin edge_hit = 1'b1; nx = '0; end
                else nx = bx[0] + CW'(1);
         LEFT:  if (bx[0] == '0) begin edge_hit = 1'b1; nx = CW'(GRID_W - 1); end
                else nx = bx[0] - CW'(1);
         UP:    if (by[0] == '0) begin edge_hit = 1'b1; ny = CW'(GRID_H - 1); end
                else ny = by[0] - CW'(1);
         DOWN:  if (by[0] == CW'(GRID_H - 1)) begin edge_hit = 1'b1; ny = '0; end
                else ny = by[0] + CW'(1);
         default: edge_hit = 1'b0;
      endcase
      wall = edge_hit && !WRAP;
   end

   // Without a pending grow the tail vacates this step, so it is not scanned.
   assign k_last = grow_pend ? IW'(len - 1'b1) : IW'(len - 2'd2);
   assign hit    = (bx[k] == nh_x) && (by[k] == nh_y);

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         k         <= '0;
         nh_x      <= '0;
         nh_y      <= '0;
         len       <= LEN_INIT;
         grow_pend <= 1'b0;
         move_done <= 1'b0;
         game_over <= 1'b0;
      end else begin
         move_done <= 1'b0;
         if (grow && state != GAME_OVER) grow_pend <= 1'b1;
         case (state)
            IDLE: if (step_tick) state <= MOVE;
            MOVE: begin
               if (wall) begin
                  state     <= GAME_OVER;
                  game_over <= 1'b1;
               end else begin
                  nh_x  <= nx;
                  nh_y  <= ny;
                  k     <= '0;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (hit) begin
                  state     <= GAME_OVER;
                  game_over <= 1'b1;
               end else if (k == k_last) begin
                  state <= COMMIT;
               end else begin
                  k <= k + 1'b1;
               end
            end
            COMMIT: begin
               if (grow_pend && len != LEN_MAX) len <= len + 1'b1;
               grow_pend <= grow;
               move_done <= 1'b1;
               state     <= IDLE;
            end
            GAME_OVER: begin
               if (restart) begin
                  state     <= IDLE;
                  k         <= '0;
                  len       <= LEN_INIT;
                  grow_pend <= 1'b0;
                  game_over <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            bx[i] <= init_x(i);
            by[i] <= init_y(i);
         end
      end else if (reinit) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            bx[i] <= init_x(i);
            by[i] <= init_y(i);
         end
      end else if (state == COMMIT) begin
         for (int i = MAX_LEN - 1; i > 0; i--) begin
            bx[i] <= bx[i-1];
            by[i] <= by[i-1];
         end
         bx[0] <= nh_x;
         by[0] <= nh_y;
      end
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         seg_x   <= '0;
         seg_y   <= '0;
         seg_vld <= 1'b0;
      end else begin
         seg_x   <= bx[seg_idx];
         seg_y   <= by[seg_idx];
         seg_vld <= {1'b0, seg_idx} < len;
      end
   end

   assign head_x    = bx[0];
   assign head_y    = by[0];
   assign snake_len = len;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl; follows WRAP_WALLS_EN when the build defines it.
module tb_snake_move_ctrl;

   logic       vga_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       step_tick = 1'b0;
   logic [3:0] key_dir = 4'd0;
   logic       grow = 1'b0;
   logic       restart = 1'b0;
   logic [5:0] seg_idx = 6'd0;
   logic [4:0] seg_x, seg_y, head_x, head_y;
   logic       seg_vld, move_done, game_over;
   logic [6:0] snake_len;

   int errors = 0;
   int checks = 0;

   localparam logic [3:0] K_UP = 4'b1000, K_DOWN = 4'b0100, K_LEFT = 4'b0010, K_RIGHT = 4'b0001;

   snake_move_ctrl dut (
      .vga_clk   (vga_clk),
      .sys_rst_n (sys_rst_n),
      .step_tick (step_tick),
      .key_dir   (key_dir),
      .grow      (grow),
      .restart   (restart),
      .seg_idx   (seg_idx),
      .seg_x     (seg_x),
      .seg_y     (seg_y),
      .seg_vld   (seg_vld),
      .head_x    (head_x),
      .head_y    (head_y),
      .snake_len (snake_len),
      .move_done (move_done),
      .game_over (game_over)
   );

   always #20 vga_clk = ~vga_clk;

   task automatic do_reset();
      @(negedge vga_clk) sys_rst_n = 1'b0;
      @(negedge vga_clk) sys_rst_n = 1'b1;
   endtask

   task automatic key(input logic [3:0] k);
      @(negedge vga_clk) key_dir = k;
      @(negedge vga_clk) key_dir = 4'd0;
   endtask

   task automatic pulse_grow();
      @(negedge vga_clk) grow = 1'b1;
      @(negedge vga_clk) grow = 1'b0;
   endtask

   task automatic step_move(output int cyc);
      cyc = 0;
      @(negedge vga_clk) step_tick = 1'b1;
      @(negedge vga_clk) step_tick = 1'b0;
      while (!move_done && !game_over && cyc < 100) begin
         @(negedge vga_clk);
         cyc++;
      end
      if (cyc >= 100) begin
         checks++; errors++;
         $display("FAIL step_timeout: no move_done/game_over after %0d cycles", cyc);
      end
   endtask

   task automatic rd(input int idx, output logic [4:0] x, output logic [4:0] y, output logic v);
      @(negedge vga_clk) seg_idx = 6'(idx);
      @(negedge vga_clk);
      x = seg_x; y = seg_y; v = seg_vld;
   endtask

   task automatic test_reset();
      logic [4:0] x, y; logic v;
      sys_rst_n = 1'b0;
      repeat (3) @(negedge vga_clk);
      checks++;
      if ({seg_x, seg_y, seg_vld, move_done, game_over} !== 13'd0) begin
         errors++; $display("FAIL reset_outputs: got %h exp 0", {seg_x, seg_y, seg_vld, move_done, game_over});
      end
      checks++;
      if ({head_x, head_y} !== {5'd16, 5'd12}) begin
         errors++; $display("FAIL reset_head: got (%0d,%0d) exp (16,12)", head_x, head_y);
      end
      checks++;
      if (snake_len !== 7'd3) begin
         errors++; $display("FAIL reset_len: got %0d exp 3", snake_len);
      end
      sys_rst_n = 1'b1;
      rd(2, x, y, v);
      checks++;
      if ({x, y, v} !== {5'd14, 5'd12, 1'b1}) begin
         errors++; $display("FAIL reset_seg2: got (%0d,%0d,%0d) exp (14,12,1)", x, y, v);
      end
      rd(3, x, y, v);
      checks++;
      if (v !== 1'b0) begin
         errors++; $display("FAIL reset_seg3_vld: got %0d exp 0", v);
      end
   endtask

   task automatic test_step();
      logic [4:0] x, y; logic v; int cyc;
      do_reset();
      step_move(cyc);
      checks++;
      if (cyc > 6) begin
         errors++; $display("FAIL step_latency: got %0d cycles exp <= 6", cyc);
      end
      checks++;
      if ({head_x, head_y, snake_len} !== {5'd17, 5'd12, 7'd3}) begin
         errors++; $display("FAIL step_head: got (%0d,%0d) len %0d exp (17,12) len 3", head_x, head_y, snake_len);
      end
      rd(2, x, y, v);
      checks++;
      if ({x, y, v} !== {5'd15, 5'd12, 1'b1}) begin
         errors++; $display("FAIL step_seg2: got (%0d,%0d,%0d) exp (15,12,1)", x, y, v);
      end
      rd(0, x, y, v);
      checks++;
      if ({x, y, v} !== {5'd17, 5'd12, 1'b1}) begin
         errors++; $display("FAIL step_seg0: got (%0d,%0d,%0d) exp (17,12,1)", x, y, v);
      end
   endtask

   task automatic test_reversal();
      int cyc;
      do_reset();
      key(K_LEFT);
      step_move(cyc);
      checks++;
      if ({head_x, head_y} !== {5'd17, 5'd12}) begin
         errors++; $display("FAIL rev_left: got (%0d,%0d) exp (17,12)", head_x, head_y);
      end
      do_reset();
      key(K_UP);
      step_move(cyc);
      checks++;
      if ({head_x, head_y} !== {5'd16, 5'd11}) begin
         errors++; $display("FAIL turn_up: got (%0d,%0d) exp (16,11)", head_x, head_y);
      end
      key(4'b0011);
      step_move(cyc);
      checks++;
      if ({head_x, head_y} !== {5'd16, 5'd10}) begin
         errors++; $display("FAIL multi_hot: got (%0d,%0d) exp (16,10)", head_x, head_y);
      end
      key(K_DOWN);
      step_move(cyc);
      checks++;
      if ({head_x, head_y} !== {5'd16, 5'd9}) begin
         errors++; $display("FAIL rev_down: got (%0d,%0d) exp (16,9)", head_x, head_y);
      end
   endtask

   task automatic test_wall();
      int cyc;
      do_reset();
      repeat (15) step_move(cyc);
      checks++;
      if ({head_x, head_y, game_over} !== {5'd31, 5'd12, 1'b0}) begin
         errors++; $display("FAIL wall_edge: got (%0d,%0d) go %0d exp (31,12) go 0", head_x, head_y, game_over);
      end
      step_move(cyc);
`ifdef WRAP_WALLS_EN
      checks++;
      if ({head_x, head_y, game_over} !== {5'd0, 5'd12, 1'b0}) begin
         errors++; $display("FAIL wall_wrap: got (%0d,%0d) go %0d exp (0,12) go 0", head_x, head_y, game_over);
      end
`else
      checks++;
      if ({head_x, head_y, game_over} !== {5'd31, 5'd12, 1'b1}) begin
         errors++; $display("FAIL wall_hit: got (%0d,%0d) go %0d exp (31,12) go 1", head_x, head_y, game_over);
      end
      @(negedge vga_clk) step_tick = 1'b1;
      @(negedge vga_clk) step_tick = 1'b0;
      repeat (10) @(negedge vga_clk);
      checks++;
      if ({head_x, head_y, game_over, snake_len} !== {5'd31, 5'd12, 1'b1, 7'd3}) begin
         errors++; $display("FAIL wall_frozen: got (%0d,%0d) go %0d len %0d exp (31,12) go 1 len 3", head_x, head_y, game_over, snake_len);
      end
`endif
   endtask

   task automatic test_grow();
      logic [4:0] x, y; logic v; int cyc; logic md;
      do_reset();
      pulse_grow();
      step_move(cyc);
      checks++;
      if ({head_x, head_y, snake_len} !== {5'd17, 5'd12, 7'd4}) begin
         errors++; $display("FAIL grow_len: got (%0d,%0d) len %0d exp (17,12) len 4", head_x, head_y, snake_len);
      end
      rd(3, x, y, v);
      checks++;
      if ({x, y, v} !== {5'd14, 5'd12, 1'b1}) begin
         errors++; $display("FAIL grow_tail: got (%0d,%0d,%0d) exp (14,12,1)", x, y, v);
      end
      // len 4, nothing pending: MOVE, three SCAN cycles, then COMMIT
      @(negedge vga_clk) step_tick = 1'b1;
      @(negedge vga_clk) step_tick = 1'b0;
      repeat (3) @(negedge vga_clk);
      @(negedge vga_clk) grow = 1'b1;
      @(negedge vga_clk) grow = 1'b0;
      md = move_done;
      checks++;
      if ({md, snake_len} !== {1'b1, 7'd4}) begin
         errors++; $display("FAIL grow_in_commit: got done %0d len %0d exp done 1 len 4", md, snake_len);
      end
      step_move(cyc);
      checks++;
      if ({head_x, head_y, snake_len} !== {5'd19, 5'd12, 7'd5}) begin
         errors++; $display("FAIL grow_held: got (%0d,%0d) len %0d exp (19,12) len 5", head_x, head_y, snake_len);
      end
      rd(4, x, y, v);
      checks++;
      if ({x, y, v} !== {5'd15, 5'd12, 1'b1}) begin
         errors++; $display("FAIL grow_held_tail: got (%0d,%0d,%0d) exp (15,12,1)", x, y, v);
      end
   endtask

   task automatic test_saturate();
      logic [4:0] x, y; logic v; int cyc;
      do_reset();
      // serpentine: right to x=31, up, left to x=1, up, right to x=16
      for (int s = 1; s <= 62; s++) begin
         if (s == 16 || s == 47) key(K_UP);
         else if (s == 17) key(K_LEFT);
         else if (s == 48) key(K_RIGHT);
         pulse_grow();
         step_move(cyc);
         if (s == 61) begin
            checks++;
            if (snake_len !== 7'd64) begin
               errors++; $display("FAIL sat_reach: got len %0d exp 64", snake_len);
            end
         end
      end
      checks++;
      if ({head_x, head_y, snake_len, game_over} !== {5'd16, 5'd10, 7'd64, 1'b0}) begin
         errors++; $display("FAIL sat_hold: got (%0d,%0d) len %0d go %0d exp (16,10) len 64 go 0", head_x, head_y, snake_len, game_over);
      end
      rd(63, x, y, v);
      checks++;
      if ({x, y, v} !== {5'd15, 5'd12, 1'b1}) begin
         errors++; $display("FAIL sat_tail: got (%0d,%0d,%0d) exp (15,12,1)", x, y, v);
      end
   endtask

   task automatic test_selfhit_restart();
      int cyc; int extra;
      do_reset();
      repeat (2) begin
         pulse_grow();
         step_move(cyc);
      end
      checks++;
      if ({head_x, head_y, snake_len} !== {5'd18, 5'd12, 7'd5}) begin
         errors++; $display("FAIL hit_setup: got (%0d,%0d) len %0d exp (18,12) len 5", head_x, head_y, snake_len);
      end
      key(K_UP);   step_move(cyc);
      key(K_LEFT); step_move(cyc);
      key(K_DOWN); step_move(cyc);
      checks++;
      if ({head_x, head_y, snake_len, game_over} !== {5'd17, 5'd11, 7'd5, 1'b1}) begin
         errors++; $display("FAIL self_hit: got (%0d,%0d) len %0d go %0d exp (17,11) len 5 go 1", head_x, head_y, snake_len, game_over);
      end
      @(negedge vga_clk) restart = 1'b1;
      @(negedge vga_clk) restart = 1'b0;
      checks++;
      if ({head_x, head_y, snake_len, game_over} !== {5'd16, 5'd12, 7'd3, 1'b0}) begin
         errors++; $display("FAIL restart: got (%0d,%0d) len %0d go %0d exp (16,12) len 3 go 0", head_x, head_y, snake_len, game_over);
      end
      // second tick lands while the first move is still scanning
      @(negedge vga_clk) step_tick = 1'b1;
      @(negedge vga_clk) step_tick = 1'b0;
      @(negedge vga_clk) step_tick = 1'b1;
      @(negedge vga_clk) step_tick = 1'b0;
      cyc = 0;
      while (!move_done && cyc < 100) begin
         @(negedge vga_clk);
         cyc++;
      end
      extra = 0;
      repeat (12) begin
         @(negedge vga_clk);
         if (move_done) extra++;
      end
      checks++;
      if ({head_x, head_y, 8'(extra)} !== {5'd17, 5'd12, 8'd0} || cyc >= 100) begin
         errors++; $display("FAIL busy_tick: got (%0d,%0d) extra %0d wait %0d exp (17,12) extra 0", head_x, head_y, extra, cyc);
      end
      @(negedge vga_clk) restart = 1'b1;
      @(negedge vga_clk) restart = 1'b0;
      repeat (2) @(negedge vga_clk);
      checks++;
      if ({head_x, head_y, snake_len} !== {5'd17, 5'd12, 7'd3}) begin
         errors++; $display("FAIL restart_ignored: got (%0d,%0d) len %0d exp (17,12) len 3", head_x, head_y, snake_len);
      end
   endtask

   task automatic test_async_abort();
      do_reset();
      pulse_grow();
      @(negedge vga_clk) step_tick = 1'b1;
      @(negedge vga_clk) step_tick = 1'b0;
      @(negedge vga_clk);
      #5 sys_rst_n = 1'b0;
      @(negedge vga_clk) sys_rst_n = 1'b1;
      repeat (10) @(negedge vga_clk);
      checks++;
      if ({head_x, head_y, snake_len, game_over} !== {5'd16, 5'd12, 7'd3, 1'b0}) begin
         errors++; $display("FAIL async_abort: got (%0d,%0d) len %0d go %0d exp (16,12) len 3 go 0", head_x, head_y, snake_len, game_over);
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_reversal();
      test_wall();
      test_grow();
      test_saturate();
      test_selfhit_restart();
      test_async_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
